lua_nd: RTL and testbench
=========================

Name: lua_nd

Overview:
- Next-generation linear-unit-address block: converts a 2-D or 3-D element coordinate into a flat byte address.
- Formula: Address = Base + (((Z*SizeY + Y)*SizeX + X) << ElemShift).
- Dimensions, base and element size are supplied at runtime, not fixed by parameter.
- Adds bounds checking and overflow detection. Sits between address generators and memory controllers, using the Start/Ready handshake.

Parameters:
- DATA_WIDTH, 16, width of coordinates X/Y/Z and dimension sizes SizeX/SizeY.
- ADDR_WIDTH, 32, width of Base and Address; final sum is taken modulo 2^ADDR_WIDTH.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Mode  input  1  0 = 2-D (Z, SizeY ignored), 1 = 3-D.
- InputX  input  DATA_WIDTH  X coordinate.
- InputY  input  DATA_WIDTH  Y coordinate.
- InputZ  input  DATA_WIDTH  Z coordinate.
- SizeX  input  DATA_WIDTH  row length in elements.
- SizeY  input  DATA_WIDTH  rows per plane.
- Base  input  ADDR_WIDTH  base byte address.
- ElemShift  input  3  log2 of element size in bytes (0..7).
- Address  output  ADDR_WIDTH  result byte address.
- Ready  output  1  1 = idle, result valid.
- Error  output  1  coordinate out of bounds on last operation.
- Overflow  output  1  full-precision address exceeded ADDR_WIDTH on last operation.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, Ready = 1, Address = 0, Error = 0, Overflow = 0; any in-flight operation is aborted with no result.
- States: IDLE, CHECK, MUL1, MUL2, FINISH.
- IDLE: when Start = 1 at edge k:
  - all inputs are latched; later input changes have no effect;
  - Ready <= 0; next state CHECK.
- CHECK (edge k+1): error if InputX >= SizeX, or (Mode = 1 and (InputY >= SizeY or InputZ >= SizeY... per-axis: InputY >= SizeY)).
  - Error case: Ready <= 1, Error <= 1, Overflow <= 0, Address <= 0; next state IDLE.
  - SizeX = 0 always errors; SizeY = 0 errors in 3-D mode only.
  - 2-D mode performs no Y bound check; SizeY and Z are ignored.
  - No error: Mode = 1 -> MUL1; Mode = 0 -> MUL2 with T = Y.
- MUL1: T = Z*SizeY + Y using the seq_mul sub-module; exactly DATA_WIDTH cycles.
  - T width 2*DATA_WIDTH, no truncation.
- MUL2: I = T*SizeX + X; exactly DATA_WIDTH cycles.
  - I width 3*DATA_WIDTH, no truncation.
- FINISH (one edge): S = Base + (I << ElemShift) at full precision.
  - Address <= S mod 2^ADDR_WIDTH.
  - Overflow <= (S >= 2^ADDR_WIDTH).
  - Error <= 0, Ready <= 1; next state IDLE.
- Latency, with Start sampled at edge k, Ready rises at:
  - edge k+1 on error;
  - edge k+2+DATA_WIDTH in 2-D mode;
  - edge k+2+2*DATA_WIDTH in 3-D mode.
- Address/Error/Overflow hold their previous values throughout a busy period and change only at completion.
- Start while busy (Ready = 0) is ignored, with no queuing.
- Start still high on the first edge after Ready rises begins a new operation (level-sensitive back-to-back use).

Decomposition:
- Shared include header lua_defs.vh holds:
  - state encodings (LUA_IDLE, LUA_CHECK, LUA_MUL1, LUA_MUL2, LUA_FINISH);
  - mode constants (LUA_MODE_2D = 0, LUA_MODE_3D = 1).
- Sub-module seq_mul: shift-add unsigned multiplier with accumulate input.
  - Parameter: WIDTH_A.
  - Ports: Clk, Reset, Start, A, B[DATA_WIDTH], Acc, Product, Done.
  - Computes A*B+Acc in exactly DATA_WIDTH cycles.
  - Instantiated once and reused for MUL1 and MUL2 (A = Z then T).

Test Plan:
- Reset: assert Reset mid-stream -> Ready = 1, Address = 0, Error = 0, Overflow = 0 immediately, without waiting for a clock edge.
- Legacy 2-D case (DATA_WIDTH = 16): Mode = 0, SizeX = 10, X = 4, Y = 5, Base = 0, ElemShift = 0 -> Address = 54, Error = 0; Ready low for exactly 18 cycles.
- 3-D case: Mode = 1, SizeX = 10, SizeY = 8, X = 3, Y = 2, Z = 1, Base = 0x1000, ElemShift = 2 -> Address = 0x119C; Ready low for exactly 34 cycles.
- Bounds error: X = 10, SizeX = 10 -> Error = 1, Address = 0, Ready low for 1 cycle. Second error case: Mode = 1, SizeY = 0 -> Error = 1.
- Overflow: Mode = 0, Base = 0xFFFFFFF0, SizeX = 0x40, X = 0x20, Y = 0 -> Address = 0x00000010, Overflow = 1.
- Busy handling: pulse Start with different inputs during MUL1 -> ignored, original result delivered. Then assert Reset during MUL2 -> Ready = 1 and Address keeps its reset value 0.

Source files
------------

// File: rtl/lua_nd_pkg.sv
// Shared types and constants for the linear-unit-address block.
package lua_nd_pkg;

    typedef enum logic [2:0] {
        LUA_IDLE   = 3'd0,
        LUA_CHECK  = 3'd1,
        LUA_MUL1   = 3'd2,
        LUA_MUL2   = 3'd3,
        LUA_FINISH = 3'd4
    } lua_state_e;

    localparam logic LUA_MODE_2D = 1'b0;
    localparam logic LUA_MODE_3D = 1'b1;

    // Width that holds Base + (I << 7) with no loss, I being 3*dw bits wide.
    function automatic int unsigned lua_sum_width(input int unsigned dw, input int unsigned aw);
        return ((aw > 3 * dw + 7) ? aw : 3 * dw + 7) + 1;
    endfunction

endpackage

// File: rtl/lua_nd_seq_mul.sv
// Shift-add unsigned multiply-accumulate: product = a*b + acc in DATA_WIDTH cycles.
module lua_nd_seq_mul #(
    parameter int unsigned WIDTH_A    = 32,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [WIDTH_A-1:0]               a,
    input  logic [DATA_WIDTH-1:0]            b,
    input  logic [DATA_WIDTH-1:0]            acc,
    output logic [WIDTH_A+DATA_WIDTH-1:0]    product,
    output logic                             done_c
);

    localparam int unsigned PW = WIDTH_A + DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    logic [PW-1:0]         a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q;

    logic                  run_c;
    logic [PW-1:0]         step_a;
    logic [PW-1:0]         step_s;
    logic [PW-1:0]         sum_n;
    logic [DATA_WIDTH-1:0] step_b;
    logic [CW-1:0]         step_cnt;

    // The start cycle consumes operands directly, so the first bit is done on the start edge.
    always_comb begin
        run_c    = start | busy_q;
        step_a   = start ? PW'(a)   : a_q;
        step_b   = start ? b        : b_q;
        step_s   = start ? PW'(acc) : product;
        step_cnt = start ? '0       : cnt_q;
        sum_n    = step_s + (step_b[0] ? step_a : '0);
        done_c   = run_c && (step_cnt == CW'(DATA_WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (run_c) begin
            product <= sum_n;
            a_q     <= step_a << 1;
            b_q     <= step_b >> 1;
            cnt_q   <= step_cnt + CW'(1);
            busy_q  <= ~done_c;
        end
    end

endmodule

// File: rtl/lua_nd.sv
// Coordinate to flat byte address: Base + (((Z*SizeY + Y)*SizeX + X) << ElemShift).
module lua_nd
    import lua_nd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] input_x,
    input  logic [DATA_WIDTH-1:0] input_y,
    input  logic [DATA_WIDTH-1:0] input_z,
    input  logic [DATA_WIDTH-1:0] size_x,
    input  logic [DATA_WIDTH-1:0] size_y,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [2:0]            elem_shift,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  ready,
    output logic                  error,
    output logic                  overflow
);

    localparam int unsigned TW = 2 * DATA_WIDTH;
    localparam int unsigned PW = 3 * DATA_WIDTH;
    localparam int unsigned SW = lua_sum_width(DATA_WIDTH, ADDR_WIDTH);

    lua_state_e            state_q, state_d;
    logic                  first_q, first_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, sx_q, sx_d, sy_q, sy_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic                  ready_d, error_d, overflow_d;

    logic                  mul_start_c;
    logic [TW-1:0]         mul_a;
    logic [DATA_WIDTH-1:0] mul_b, mul_acc;
    logic [PW-1:0]         mul_prod;
    logic                  mul_done_c;
    logic [SW-1:0]         sum_c;

    // One multiplier serves both passes: Z*SizeY+Y, then T*SizeX+X.
    lua_nd_seq_mul #(
        .WIDTH_A    (TW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_c),
        .a       (mul_a),
        .b       (mul_b),
        .acc     (mul_acc),
        .product (mul_prod),
        .done_c  (mul_done_c)
    );

    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        base_d      = base_q;
        shift_d     = shift_q;
        address_d   = address;
        ready_d     = ready;
        error_d     = error;
        overflow_d  = overflow;
        mul_start_c = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        mul_acc     = '0;
        sum_c       = '0;
        case (state_q)
            LUA_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    x_d     = input_x;
                    y_d     = input_y;
                    z_d     = input_z;
                    sx_d    = size_x;
                    sy_d    = size_y;
                    base_d  = base;
                    shift_d = elem_shift;
                    ready_d = 1'b0;
                    state_d = LUA_CHECK;
                end
            end
            LUA_CHECK: begin
                // Z has no size of its own, so only X and (in 3-D) Y are bounded.
                if ((x_q >= sx_q) || ((mode_q == LUA_MODE_3D) && (y_q >= sy_q))) begin
                    ready_d    = 1'b1;
                    error_d    = 1'b1;
                    overflow_d = 1'b0;
                    address_d  = '0;
                    state_d    = LUA_IDLE;
                end else begin
                    first_d = 1'b1;
                    state_d = (mode_q == LUA_MODE_3D) ? LUA_MUL1 : LUA_MUL2;
                end
            end
            LUA_MUL1: begin
                mul_start_c = first_q;
                mul_a       = TW'(z_q);
                mul_b       = sy_q;
                mul_acc     = y_q;
                if (mul_done_c) begin
                    first_d = 1'b1;
                    state_d = LUA_MUL2;
                end
            end
            LUA_MUL2: begin
                mul_start_c = first_q;
                mul_a       = (mode_q == LUA_MODE_3D) ? mul_prod[TW-1:0] : TW'(y_q);
                mul_b       = sx_q;
                mul_acc     = x_q;
                if (mul_done_c) begin
                    state_d = LUA_FINISH;
                end
            end
            LUA_FINISH: begin
                sum_c      = SW'(base_q) + (SW'(mul_prod) << shift_q);
                address_d  = sum_c[ADDR_WIDTH-1:0];
                overflow_d = |sum_c[SW-1:ADDR_WIDTH];
                error_d    = 1'b0;
                ready_d    = 1'b1;
                state_d    = LUA_IDLE;
            end
            default: begin
                state_d = LUA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LUA_IDLE;
            first_q  <= 1'b0;
            mode_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            base_q   <= '0;
            shift_q  <= '0;
            address  <= '0;
            ready    <= 1'b1;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            mode_q   <= mode_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            base_q   <= base_d;
            shift_q  <= shift_d;
            address  <= address_d;
            ready    <= ready_d;
            error    <= error_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_lua_nd.sv
// Bench for lua_nd: directed vector table, busy/reset/back-to-back sequences, random ops vs model.
module tb_lua_nd;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] input_x, input_y, input_z, size_x, size_y;
    logic [31:0] base;
    logic [2:0]  elem_shift;
    logic [31:0] address;
    logic        ready, error, overflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prev_a = 32'h0;
    logic        prev_e = 1'b0;
    logic        prev_o = 1'b0;

    typedef struct {
        logic        m;
        logic [15:0] x, y, z, sx, sy;
        logic [31:0] base;
        logic [2:0]  sh;
        logic [31:0] ea;
        logic        ee, eo;
        int          el;
    } vec_t;

    lua_nd #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .input_x    (input_x),
        .input_y    (input_y),
        .input_z    (input_z),
        .size_x     (size_x),
        .size_y     (size_y),
        .base       (base),
        .elem_shift (elem_shift),
        .address    (address),
        .ready      (ready),
        .error      (error),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z, input logic [15:0] sx, input logic [15:0] sy,
                                input logic [31:0] b, input logic [2:0] sh, input logic [31:0] ea,
                                input logic ee, input logic eo, input int el);
        vec_t v;
        v.m = m; v.x = x; v.y = y; v.z = z; v.sx = sx; v.sy = sy;
        v.base = b; v.sh = sh; v.ea = ea; v.ee = ee; v.eo = eo; v.el = el;
        return v;
    endfunction

    // Reference: address arithmetic straight from the formula in 64-bit integers.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        longint unsigned idx, s;
        r = v;
        if ((v.x >= v.sx) || (v.m && (v.y >= v.sy))) begin
            r.ea = 32'h0; r.ee = 1'b1; r.eo = 1'b0; r.el = 1;
        end else begin
            if (v.m)
                idx = (64'(v.z) * 64'(v.sy) + 64'(v.y)) * 64'(v.sx) + 64'(v.x);
            else
                idx = 64'(v.y) * 64'(v.sx) + 64'(v.x);
            s = 64'(v.base) + (idx << v.sh);
            r.ea = s[31:0];
            r.eo = ((s >> 32) != 0);
            r.ee = 1'b0;
            r.el = v.m ? 2 + 2 * 16 : 2 + 16;
        end
        return r;
    endfunction

    task automatic apply(input vec_t v);
        mode = v.m; input_x = v.x; input_y = v.y; input_z = v.z;
        size_x = v.sx; size_y = v.sy; base = v.base; elem_shift = v.sh;
    endtask

    task automatic scramble();
        mode = 1'($urandom); input_x = 16'($urandom); input_y = 16'($urandom);
        input_z = 16'($urandom); size_x = 16'($urandom); size_y = 16'($urandom);
        base = $urandom; elem_shift = 3'($urandom);
    endtask

    // Count cycles until ready; optionally pulse start (with junk inputs) at cycle pulse_at.
    task automatic wait_ready(input int pulse_at, output int cyc, output bit hold_ok);
        cyc = 0;
        hold_ok = 1'b1;
        while (ready !== 1'b1 && cyc < 200) begin
            if (address !== prev_a || error !== prev_e || overflow !== prev_o) hold_ok = 1'b0;
            if (cyc == pulse_at) begin
                start = 1'b1;
                scramble();
            end
            @(posedge clk);
            #1;
            if (cyc == pulse_at) start = 1'b0;
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input vec_t v, input int cyc, input bit hold_ok);
        check({name, "_addr"}, 64'(address), 64'(v.ea));
        check({name, "_err"}, 64'(error), 64'(v.ee));
        check({name, "_ovf"}, 64'(overflow), 64'(v.eo));
        check({name, "_lat"}, 64'(cyc), 64'(v.el));
        check({name, "_hold"}, 64'(hold_ok), 64'(1));
        prev_a = v.ea; prev_e = v.ee; prev_o = v.eo;
    endtask

    task automatic run_op(input vec_t v, input int pulse_at, input string name);
        int cyc;
        bit hold_ok;
        @(negedge clk);
        apply(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        wait_ready(pulse_at, cyc, hold_ok);
        check_result(name, v, cyc, hold_ok);
    endtask

    vec_t tbl[12];

    initial begin
        int   cyc;
        bit   hold_ok;
        bit   idle_ok;
        vec_t v;

        tbl[0]  = mk(1'b0, 16'd4, 16'd5, 16'd0, 16'd10, 16'd0, 32'h0, 3'd0, 32'd54, 1'b0, 1'b0, 18);
        tbl[1]  = mk(1'b1, 16'd3, 16'd2, 16'd1, 16'd10, 16'd8, 32'h1000, 3'd2, 32'h119C, 1'b0, 1'b0, 34);
        tbl[2]  = mk(1'b0, 16'd10, 16'd0, 16'd0, 16'd10, 16'd0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0, 1);
        tbl[3]  = mk(1'b1, 16'd0, 16'd0, 16'd0, 16'd10, 16'd0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0, 1);
        tbl[4]  = mk(1'b0, 16'h20, 16'd0, 16'd0, 16'h40, 16'd0, 32'hFFFFFFF0, 3'd0, 32'h10, 1'b0, 1'b1, 18);
        tbl[5]  = mk(1'b0, 16'd2, 16'd100, 16'd5, 16'd3, 16'd0, 32'h0, 3'd0, 32'd302, 1'b0, 1'b0, 18);
        tbl[6]  = mk(1'b1, 16'd1, 16'd4, 16'd0, 16'd5, 16'd4, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0, 1);
        tbl[7]  = mk(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'h55, 3'd0, 32'h0, 1'b1, 1'b0, 1);
        tbl[8]  = mk(1'b1, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h0, 3'd7, 32'h007FFF80, 1'b0, 1'b1, 34);
        tbl[9]  = mk(1'b0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 18);
        tbl[10] = mk(1'b0, 16'd1, 16'd0, 16'd0, 16'd2, 16'd0, 32'hFFFFFFFF, 3'd0, 32'h0, 1'b0, 1'b1, 18);
        tbl[11] = mk(1'b1, 16'd4, 16'd7, 16'd3, 16'd5, 16'd8, 32'h100, 3'd1, 32'h23E, 1'b0, 1'b0, 34);

        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        scramble();
        #1;
        check("reset_ready", 64'(ready), 64'(1));
        check("reset_addr", 64'(address), 64'(0));
        check("reset_err", 64'(error), 64'(0));
        check("reset_ovf", 64'(overflow), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_op(tbl[i], -1, $sformatf("vec%0d", i));

        // Start pulse in the middle of MUL1 must be dropped.
        run_op(tbl[1], 5, "busy");
        idle_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b1) idle_ok = 1'b0;
        end
        check("busy_no_queue", 64'(idle_ok), 64'(1));

        // Asynchronous reset during MUL2 aborts the operation.
        @(negedge clk);
        apply(tbl[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(ready), 64'(1));
        check("midrst_addr", 64'(address), 64'(0));
        check("midrst_err", 64'(error), 64'(0));
        check("midrst_ovf", 64'(overflow), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b1 || address !== 32'h0) idle_ok = 1'b0;
        end
        check("midrst_no_result", 64'(idle_ok), 64'(1));
        prev_a = 32'h0; prev_e = 1'b0; prev_o = 1'b0;

        // Start held high across completion launches the next op immediately.
        @(negedge clk);
        apply(tbl[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(-1, cyc, hold_ok);
        check_result("b2b_first", tbl[0], cyc, hold_ok);
        apply(tbl[5]);
        @(posedge clk);
        #1;
        check("b2b_restart", 64'(ready), 64'(0));
        start = 1'b0;
        wait_ready(-1, cyc, hold_ok);
        check_result("b2b_second", tbl[5], cyc, hold_ok);

        for (int i = 0; i < 40; i++) begin
            v.m = 1'($urandom);
            if (i % 4 == 3) begin
                v.x = 16'($urandom); v.y = 16'($urandom); v.z = 16'($urandom);
                v.sx = 16'($urandom); v.sy = 16'($urandom);
            end else begin
                v.x = 16'($urandom_range(0, 24)); v.y = 16'($urandom_range(0, 24));
                v.z = 16'($urandom_range(0, 24)); v.sx = 16'($urandom_range(0, 24));
                v.sy = 16'($urandom_range(0, 24));
            end
            v.base = $urandom;
            v.sh = 3'($urandom_range(0, 7));
            v = model(v);
            run_op(v, -1, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
